// File: rtl/serializer8.sv
// 8-bit parallel-to-serial converter with valid/ready handshakes on both sides.
// Bit order is chosen by MSB_FIRST; a word can follow the previous one with no idle cycle.
module serializer8 #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ser_out,
    output logic       ser_valid,
    input  logic       ser_ready,
    output logic       ser_last,
    output logic [2:0] ctrl,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t     r_state;
    logic [2:0] r_cnt;
    logic [7:0] r_word;

    state_t     w_state_next;
    logic [2:0] w_cnt_next;
    logic [7:0] w_word_next;
    logic       w_shift;
    logic       w_last;
    logic       w_in_ready;
    logic       w_in_fire;
    logic       w_ser_fire;
    logic [2:0] w_ctrl;

    always_comb begin
        w_shift    = (r_state == SHIFT);
        w_last     = w_shift && (r_cnt == 3'd7);
        // rst_n gates in_ready so nothing is offered while reset is held.
        w_in_ready = rst_n && (!w_shift || (w_last && ser_ready));
        w_in_fire  = in_valid && w_in_ready;
        w_ser_fire = w_shift && ser_ready;
        w_ctrl     = MSB_FIRST ? (3'd7 - r_cnt) : r_cnt;
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_word_next  = r_word;
        if (w_in_fire) begin
            // Loading takes priority over the return to IDLE on the last bit.
            w_word_next  = in_data;
            w_cnt_next   = 3'd0;
            w_state_next = SHIFT;
        end else if (w_ser_fire) begin
            if (r_cnt == 3'd7) begin
                w_cnt_next   = 3'd0;
                w_state_next = IDLE;
            end else begin
                w_cnt_next = r_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_word  <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_word  <= w_word_next;
        end
    end

    assign in_ready  = w_in_ready;
    assign ser_valid = w_shift;
    assign busy      = w_shift;
    assign ser_last  = w_last;
    assign ctrl      = w_ctrl;
    assign ser_out   = w_shift ? r_word[w_ctrl] : 1'b0;

endmodule

// File: tb/tb_serializer8.sv
// Bench for serializer8: both bit orders run side by side from shared stimulus and are
// compared against a queue-of-bits model plus fixed vectors and directed corner cases.
module tb_serializer8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       ser_ready = 1'b0;

    logic       in_ready0, ser_out0, ser_valid0, ser_last0, busy0;
    logic       in_ready1, ser_out1, ser_valid1, ser_last1, busy1;
    logic [2:0] ctrl0, ctrl1;

    int n_chk = 0;
    int n_fail = 0;

    // Pending bits (and their indices) still to be sent for each bit order.
    bit         q0[$];
    bit         q1[$];
    logic [2:0] qc0[$];
    logic [2:0] qc1[$];

    always #5 clk = ~clk;

    serializer8 #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .ser_out(ser_out0), .ser_valid(ser_valid0),
        .ser_ready(ser_ready), .ser_last(ser_last0), .ctrl(ctrl0), .busy(busy0)
    );

    serializer8 #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .ser_out(ser_out1), .ser_valid(ser_valid1),
        .ser_ready(ser_ready), .ser_last(ser_last1), .ctrl(ctrl1), .busy(busy1)
    );

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       sr;
        logic       ev;
        logic       eo;
        logic [2:0] ec0;
        logic [2:0] ec1;
        logic       el;
        logic       er;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic set_in(input logic iv, input logic [7:0] id, input logic sr);
        in_valid  = iv;
        in_data   = id;
        ser_ready = sr;
        #1;
    endtask

    task automatic clear_model();
        q0.delete(); q1.delete(); qc0.delete(); qc1.delete();
    endtask

    // Compare every output against the model, then advance the model over one rising edge.
    task automatic model_step();
        logic       exp_v, exp_l, exp_r, fire_in, fire_ser;
        logic [7:0] d;
        int         n;
        n     = q0.size();
        exp_v = (n != 0);
        exp_l = (n == 1);
        exp_r = rst_n && ((n == 0) || ((n == 1) && ser_ready));
        chk("ser_valid0", {7'd0, ser_valid0}, {7'd0, exp_v});
        chk("ser_valid1", {7'd0, ser_valid1}, {7'd0, exp_v});
        chk("busy0", {7'd0, busy0}, {7'd0, exp_v});
        chk("busy1", {7'd0, busy1}, {7'd0, exp_v});
        chk("ser_last0", {7'd0, ser_last0}, {7'd0, exp_l});
        chk("ser_last1", {7'd0, ser_last1}, {7'd0, exp_l});
        chk("in_ready0", {7'd0, in_ready0}, {7'd0, exp_r});
        chk("in_ready1", {7'd0, in_ready1}, {7'd0, exp_r});
        chk("ser_out0", {7'd0, ser_out0}, {7'd0, exp_v ? q0[0] : 1'b0});
        chk("ser_out1", {7'd0, ser_out1}, {7'd0, exp_v ? q1[0] : 1'b0});
        chk("ctrl0", {5'd0, ctrl0}, {5'd0, exp_v ? qc0[0] : 3'd0});
        chk("ctrl1", {5'd0, ctrl1}, {5'd0, exp_v ? qc1[0] : 3'd7});
        fire_in  = in_valid && exp_r;
        fire_ser = exp_v && ser_ready;
        d        = in_data;
        @(posedge clk);
        if (!rst_n) begin
            clear_model();
        end else begin
            if (fire_ser) begin
                void'(q0.pop_front()); void'(q1.pop_front());
                void'(qc0.pop_front()); void'(qc1.pop_front());
            end
            if (fire_in) begin
                for (int i = 0; i < 8; i++) begin
                    q0.push_back(d[i]);
                    qc0.push_back(3'(i));
                    q1.push_back(d[7-i]);
                    qc1.push_back(3'(7 - i));
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int tally_v, tally_one, tally_rdy;

        // 8'hA5 in both orders: idle, eight bits, idle again.
        vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 3'd0, 3'd7, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd0, 3'd7, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 3'd6, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd2, 3'd5, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd3, 3'd4, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd4, 3'd3, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd5, 3'd2, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd6, 3'd1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd7, 3'd0, 1'b1, 1'b1};
        vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 3'd7, 1'b0, 1'b1};

        // Reset held: everything quiet, in_ready low.
        @(negedge clk);
        set_in(1'b1, 8'h77, 1'b1);
        chk("rst_in_ready", {7'd0, in_ready0}, 8'd0);
        model_step();
        model_step();
        rst_n = 1'b1;
        set_in(1'b0, 8'h00, 1'b1);
        chk("post_rst_in_ready", {7'd0, in_ready0}, 8'd1);
        model_step();

        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i].iv, vecs[i].id, vecs[i].sr);
            chk($sformatf("vec%0d_valid", i), {7'd0, ser_valid0}, {7'd0, vecs[i].ev});
            chk($sformatf("vec%0d_out0", i), {7'd0, ser_out0}, {7'd0, vecs[i].eo});
            chk($sformatf("vec%0d_out1", i), {7'd0, ser_out1}, {7'd0, vecs[i].eo});
            chk($sformatf("vec%0d_ctrl0", i), {5'd0, ctrl0}, {5'd0, vecs[i].ec0});
            chk($sformatf("vec%0d_ctrl1", i), {5'd0, ctrl1}, {5'd0, vecs[i].ec1});
            chk($sformatf("vec%0d_last", i), {7'd0, ser_last0}, {7'd0, vecs[i].el});
            chk($sformatf("vec%0d_ready", i), {7'd0, in_ready0}, {7'd0, vecs[i].er});
            model_step();
        end

        // Back-to-back 8'hFF then 8'h00 with no bubble.
        set_in(1'b1, 8'hFF, 1'b1);
        model_step();
        tally_v = 0; tally_one = 0; tally_rdy = 0;
        for (int k = 0; k < 16; k++) begin
            set_in(k < 8, 8'h00, 1'b1);
            tally_v   += int'(ser_valid0);
            tally_one += int'(ser_valid0 && ser_out0);
            if (k < 8) tally_rdy += int'(in_ready0);
            model_step();
        end
        chk("b2b_valid_cycles", 8'(tally_v), 8'd16);
        chk("b2b_ones", 8'(tally_one), 8'd8);
        chk("b2b_ready_pulses", 8'(tally_rdy), 8'd1);

        // 8'h3C with ser_ready low for three cycles at bit 2.
        set_in(1'b1, 8'h3C, 1'b1);
        model_step();
        tally_v = 0;
        for (int k = 0; k < 11; k++) begin
            set_in(1'b0, 8'h00, !(k >= 2 && k < 5));
            tally_v += int'(ser_valid0 && ser_ready);
            if (k >= 2 && k <= 5) begin
                chk("stall_ctrl0", {5'd0, ctrl0}, 8'd2);
                chk("stall_out0", {7'd0, ser_out0}, 8'd1);
            end
            model_step();
        end
        chk("stall_bits_sent", 8'(tally_v), 8'd8);
        set_in(1'b0, 8'h00, 1'b1);
        chk("stall_idle_after_11", {7'd0, ser_valid0}, 8'd0);
        model_step();

        // New word offered mid-word must be ignored.
        set_in(1'b1, 8'hA5, 1'b1);
        model_step();
        for (int k = 0; k < 9; k++) begin
            set_in(k == 3, (k == 3) ? 8'hFF : 8'h00, 1'b1);
            model_step();
        end

        // Asynchronous reset at bit 4 then a fresh word.
        set_in(1'b1, 8'h96, 1'b1);
        model_step();
        for (int k = 0; k < 4; k++) begin
            set_in(1'b0, 8'h00, 1'b1);
            model_step();
        end
        rst_n = 1'b0;
        #1;
        clear_model();
        chk("async_rst_valid", {7'd0, ser_valid0}, 8'd0);
        chk("async_rst_busy", {7'd0, busy1}, 8'd0);
        chk("async_rst_out", {7'd0, ser_out0}, 8'd0);
        model_step();
        rst_n = 1'b1;
        set_in(1'b1, 8'h5A, 1'b1);
        chk("rst_release_ready", {7'd0, in_ready0}, 8'd1);
        model_step();
        set_in(1'b0, 8'h00, 1'b1);
        chk("rst_new_ctrl0", {5'd0, ctrl0}, 8'd0);
        chk("rst_new_out0", {7'd0, ser_out0}, 8'd0);
        model_step();

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            set_in($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
            model_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
